// File: rtl/data_capture.sv
// Operand capture stage: edge-detected capture strobe fills an NWORDS-deep bank
// while loaddata is high, then freezes the bank and flags inputdata_ready until reset.
module data_capture #(
    parameter int WIDTH  = 8,
    parameter int NWORDS = 4,
    parameter int CW     = $clog2(NWORDS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    loaddata,
    input  logic                    capture,
    input  logic [WIDTH-1:0]        data_in,
    output logic                    inputdata_ready,
    output logic [CW-1:0]           word_count,
    output logic [NWORDS*WIDTH-1:0] data_out
);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_FULL    = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    cap_prev_q;
    logic [CW-1:0]           word_count_q, word_count_d;
    logic                    ready_q, ready_d;
    logic [NWORDS*WIDTH-1:0] bank_q, bank_d;
    logic                    cap_edge_s;

    assign cap_edge_s = capture & ~cap_prev_q;

    // Next-state logic: one slot write per accepted capture edge, then lock in FULL.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        ready_d      = ready_q;
        bank_d       = bank_q;
        case (state_q)
            S_COLLECT: begin
                if (loaddata && cap_edge_s) begin
                    for (int k = 0; k < NWORDS; k++) begin
                        if (word_count_q == CW'(k)) begin
                            bank_d[k*WIDTH +: WIDTH] = data_in;
                        end else begin
                            bank_d[k*WIDTH +: WIDTH] = bank_q[k*WIDTH +: WIDTH];
                        end
                    end
                    word_count_d = word_count_q + CW'(1);
                    if (word_count_q == CW'(NWORDS - 1)) begin
                        state_d = S_FULL;
                        ready_d = 1'b1;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_FULL: begin
                state_d      = S_FULL;
                ready_d      = 1'b1;
                word_count_d = CW'(NWORDS);
            end
            default: begin
                state_d = S_COLLECT;
            end
        endcase
    end

    // State registers; cap_prev resets high so a button held through reset is not a capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_COLLECT;
            cap_prev_q   <= 1'b1;
            word_count_q <= '0;
            ready_q      <= 1'b0;
            bank_q       <= '0;
        end else begin
            state_q      <= state_d;
            cap_prev_q   <= capture;
            word_count_q <= word_count_d;
            ready_q      <= ready_d;
            bank_q       <= bank_d;
        end
    end

    assign inputdata_ready = ready_q;
    assign word_count      = word_count_q;
    assign data_out        = bank_q;

endmodule

// File: tb/tb_data_capture.sv
// Directed bench for data_capture: per-cycle vector table plus a control-unit handshake sequence.
module tb_data_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        loaddata;
    logic        capture;
    logic [7:0]  data_in;
    logic        inputdata_ready;
    logic [2:0]  word_count;
    logic [31:0] data_out;

    logic tb_ld;
    logic cu_mode;
    logic cu_seen;
    logic cu_ld;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        rst;
        logic        ld;
        logic        cap;
        logic [7:0]  din;
        logic [2:0]  exp_cnt;
        logic        exp_rdy;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    assign loaddata = cu_mode ? cu_ld : tb_ld;

    // Control unit model: registers ready, then drops loaddata on the following edge.
    always @(posedge clk) begin
        if (reset) begin
            cu_seen <= 1'b0;
            cu_ld   <= 1'b1;
        end else begin
            cu_seen <= inputdata_ready;
            cu_ld   <= ~cu_seen;
        end
    end

    data_capture dut (
        .clk             (clk),
        .reset           (reset),
        .loaddata        (loaddata),
        .capture         (capture),
        .data_in         (data_in),
        .inputdata_ready (inputdata_ready),
        .word_count      (word_count),
        .data_out        (data_out)
    );

    task automatic add(input logic r, input logic l, input logic c, input logic [7:0] d,
                       input logic [2:0] ec, input logic er, input logic [31:0] ed);
        vec_t v;
        v.rst = r; v.ld = l; v.cap = c; v.din = d;
        v.exp_cnt = ec; v.exp_rdy = er; v.exp_dout = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests_run++;
        if (got !== req) begin
            tests_failed++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Drive inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic cycle(input logic r, input logic c, input logic [7:0] d);
        reset = r; capture = c; data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] bank_snap;
        reset = 1'b1; tb_ld = 1'b0; cu_mode = 1'b0; capture = 1'b1; data_in = 8'h00;

        // Scenario 1: reset with button held, then held after reset
        add(1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 32'h0);
        add(1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b1, 8'h5A, 3'd0, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b1, 8'h5A, 3'd0, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b1, 8'h5A, 3'd0, 1'b0, 32'h0);
        // Scenario 2: full set
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b0, 32'h0000_0011);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 32'h0000_0011);
        add(1'b0, 1'b1, 1'b1, 8'h22, 3'd2, 1'b0, 32'h0000_2211);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0, 32'h0000_2211);
        add(1'b0, 1'b1, 1'b1, 8'h33, 3'd3, 1'b0, 32'h0033_2211);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 32'h0033_2211);
        add(1'b0, 1'b1, 1'b1, 8'h44, 3'd4, 1'b1, 32'h4433_2211);
        // Scenario 4: captures while FULL
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd4, 1'b1, 32'h4433_2211);
        add(1'b0, 1'b1, 1'b1, 8'hFF, 3'd4, 1'b1, 32'h4433_2211);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd4, 1'b1, 32'h4433_2211);
        // Scenario 3: long press, gating, completion
        add(1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b1, 8'h55, 3'd1, 1'b0, 32'h0000_0055);
        add(1'b0, 1'b1, 1'b1, 8'h66, 3'd1, 1'b0, 32'h0000_0055);
        add(1'b0, 1'b1, 1'b1, 8'h67, 3'd1, 1'b0, 32'h0000_0055);
        add(1'b0, 1'b1, 1'b1, 8'h68, 3'd1, 1'b0, 32'h0000_0055);
        add(1'b0, 1'b1, 1'b1, 8'h69, 3'd1, 1'b0, 32'h0000_0055);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 32'h0000_0055);
        add(1'b0, 1'b0, 1'b1, 8'hAA, 3'd1, 1'b0, 32'h0000_0055);
        add(1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 32'h0000_0055);
        add(1'b0, 1'b1, 1'b1, 8'h66, 3'd2, 1'b0, 32'h0000_6655);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0, 32'h0000_6655);
        add(1'b0, 1'b1, 1'b1, 8'h77, 3'd3, 1'b0, 32'h0077_6655);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 32'h0077_6655);
        add(1'b0, 1'b1, 1'b1, 8'h88, 3'd4, 1'b1, 32'h8877_6655);
        // Scenario 5: reset on a capture edge mid-set, then refill from slot 0
        add(1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b0, 32'h0000_0011);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 32'h0000_0011);
        add(1'b0, 1'b1, 1'b1, 8'h22, 3'd2, 1'b0, 32'h0000_2211);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0, 32'h0000_2211);
        add(1'b1, 1'b1, 1'b1, 8'h99, 3'd0, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b1, 8'hA1, 3'd1, 1'b0, 32'h0000_00A1);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 32'h0000_00A1);
        add(1'b0, 1'b1, 1'b1, 8'hB2, 3'd2, 1'b0, 32'h0000_B2A1);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0, 32'h0000_B2A1);
        add(1'b0, 1'b1, 1'b1, 8'hC3, 3'd3, 1'b0, 32'h00C3_B2A1);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 32'h00C3_B2A1);
        add(1'b0, 1'b1, 1'b1, 8'hD4, 3'd4, 1'b1, 32'hD4C3_B2A1);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            tb_ld = vecs[i].ld;
            cycle(vecs[i].rst, vecs[i].cap, vecs[i].din);
            tests_run++;
            if (word_count !== vecs[i].exp_cnt || inputdata_ready !== vecs[i].exp_rdy ||
                data_out !== vecs[i].exp_dout) begin
                tests_failed++;
                $display("FAIL vec%0d: got cnt=%0d rdy=%b dout=%h, required cnt=%0d rdy=%b dout=%h",
                         i, word_count, inputdata_ready, data_out,
                         vecs[i].exp_cnt, vecs[i].exp_rdy, vecs[i].exp_dout);
            end
        end

        // Scenario 6: loaddata from the control unit model
        cu_mode = 1'b1;
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        check("cu_ld_after_reset", {31'd0, loaddata}, 32'd1);
        cycle(1'b0, 1'b1, 8'h01);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h02);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h03);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h04);
        check("cu_ready_at_t", {31'd0, inputdata_ready}, 32'd1);
        check("cu_ld_at_t", {31'd0, loaddata}, 32'd1);
        bank_snap = data_out;
        check("cu_bank", data_out, 32'h0403_0201);
        cycle(1'b0, 1'b0, 8'h00);
        check("cu_ld_at_t1", {31'd0, loaddata}, 32'd1);
        cycle(1'b0, 1'b1, 8'hEE);
        check("cu_ld_at_t2", {31'd0, loaddata}, 32'd0);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'hEF);
        check("cu_bank_frozen", data_out, 32'h0403_0201);
        check("cu_bank_vs_snap", data_out, bank_snap);
        check("cu_count", {29'd0, word_count}, 32'd4);
        check("cu_ready_held", {31'd0, inputdata_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_capture.md
# data_capture

Upstream input stage that gathers the operand set for the processing unit. While the control unit holds `loaddata` high, each rising edge of the `capture` strobe writes `data_in` into the next slot of an NWORDS-deep register bank. Once the bank is full, the block asserts `inputdata_ready`, which the control unit consumes to move to its result state. The captured words are presented in parallel on `data_out` to the datapath.

## Interface
- `WIDTH`, default 8: bits per captured word.
- `NWORDS`, default 4: number of words per operand set; must be ≥ 2.
- `CW`, default `$clog2(NWORDS+1)`: width of the word counter. Derived; do not override.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `loaddata`  in  1  load enable from the control unit; captures are accepted only while it is high.
- `capture`  in  1  synchronous capture level (debounced button); its rising edge requests one write.
- `data_in`  in  WIDTH  word to capture.
- `inputdata_ready`  out  1  registered; high while all NWORDS slots hold valid data.
- `word_count`  out  CW  registered; number of words captured so far (0..NWORDS).
- `data_out`  out  NWORDS*WIDTH  registered bank; slot k occupies bits [k*WIDTH +: WIDTH]; slot 0 is the first word captured.

## Operation
- Edge detect: `cap_prev` is a register tracking `capture`. The internal strobe is `cap_edge = capture & ~cap_prev`. On reset, `cap_prev` is set to 1, so a button already held through reset does not cause a capture.
- The state machine has two states:
  - **COLLECT** (the reset state):
    - If `loaddata & cap_edge`, write `data_in` to slot[`word_count`] and increment `word_count`.
    - If that write fills slot NWORDS-1, go to FULL and set `inputdata_ready` to 1 on the same edge.
    - If `loaddata` = 0, the capture is ignored. `word_count` and the bank hold their values (a pause, not a clear).
  - **FULL**:
    - `inputdata_ready` = 1 and `word_count` = NWORDS.
    - All captures are ignored and the bank is frozen.
    - The only exit is `reset`. There is no wrap-around; `word_count` never exceeds NWORDS.
- Values after reset: state = COLLECT, `word_count` = 0, `inputdata_ready` = 0, `data_out` = 0, `cap_prev` = 1.
- Reset has priority over every other event on the same edge, including a capture edge and the final-word write.
- Reset applied mid-operation discards any partial set. The bank is zeroed and collection restarts at slot 0.
- `data_in` is sampled only on the edge where `cap_edge & loaddata` is true. It is don't-care at all other times.

## Timing
- A capture edge at clock edge t (`capture` sampled 0 at t-1 and 1 at t) updates the slot and `word_count` at edge t, so the new values are visible after t. Latency is one cycle from the sampled level change.
- A held `capture` produces exactly one write. A new write requires `capture` to be sampled low for at least one cycle.
- Maximum capture rate is one word every 2 cycles (high, low, high).
- `inputdata_ready` rises on the same edge that writes the last word. The control unit sees it at the next edge, and `loaddata` falls one cycle after that. Captures during that window are ignored because the block is already in FULL.
- All outputs are driven directly from registers, with no combinational path from inputs to outputs.

## Test plan
1. **Reset values.** Assert `reset` for 2 cycles with `capture`=1. Then deassert `reset` and hold `capture`=1 for 3 more cycles. Required: `word_count`=0, `inputdata_ready`=0, `data_out`=0 throughout; a held button produces no capture.
2. **Full set.** Hold `loaddata`=1 and apply 4 capture pulses with `data_in` = 0x11, 0x22, 0x33, 0x44. Required: `word_count` steps 1, 2, 3, 4; `data_out`=0x44332211; `inputdata_ready` rises on the edge of the 4th write.
3. **Long press and gating.** Hold `capture` high for 5 cycles, which must count as exactly 1 word. Then drop `loaddata` to 0 and pulse `capture` with 0xAA. Required: `word_count` stays 1 and slot 1 stays 0. Restore `loaddata` and continue: the set completes normally.
4. **Captures while FULL.** After scenario 2, pulse `capture` with 0xFF. Required: `data_out` stays 0x44332211, `word_count` stays 4, `inputdata_ready` stays 1.
5. **Reset mid-operation.** After 2 captures (0x11, 0x22), assert `reset` on the same edge as a capture edge with 0x99. Required: all values return to their reset state and 0x99 is not written. A following 4-word set fills from slot 0.
6. **Integration with the control unit.** Connect `inputdata_ready` to the control unit and drive `loaddata` from it. Required: `loaddata` falls exactly 2 cycles after the 4th capture edge and the bank is unchanged afterwards.
